bin2seg_seq: RTL and testbench
==============================

# bin2seg_seq

Sequential, parametrised binary-to-decimal seven-segment driver: the successor to our combinational per-digit converter. It accepts a WIDTH-bit unsigned value through a valid/ready handshake and converts it with a double-dabble shift/add-3 engine, one bit per clock. It then drives DIGITS registered seven-segment codes plus the raw BCD. Added behaviour: leading-zero blanking, an overflow indication, selectable segment polarity, and a done pulse. It sits between the ADC/UART data path and the board's HEX displays.

## Interface
- WIDTH, 16, input value width in bits; legal range 4..32.
- DIGITS, 5, number of decimal digits and displays driven; legal range 1..10.
- SEG_ACTIVE_LOW, 1, 1 = segment lit when bit is 0 (DE-board HEX); 0 = lit when 1.
- clk  input  1  sole clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data and blank_en are presented.
- in_ready  output  1  block is idle and will accept on this edge.
- in_data  input  WIDTH  unsigned value to display.
- blank_en  input  1  leading-zero blanking for this conversion; sampled with in_data.
- seg_out  output  7*DIGITS  digit i at bits [7i+6:7i]; bit order g,f,e,d,c,b,a (bit 6 = g); digit 0 = least significant.
- bcd_out  output  4*DIGITS  BCD result; digit i at [4i+3:4i].
- overflow  output  1  last conversion did not fit in DIGITS digits.
- done  output  1  one-cycle pulse when outputs have just updated.

## Operation
- Segment map, active-high form: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, dash=0x40, blank=0x00.
- When SEG_ACTIVE_LOW=1, the 7-bit code is inverted at the output register.
- States are IDLE, SHIFT and UPDATE.
- IDLE:
  - in_ready=1.
  - On in_valid=1, capture in_data into the shift register and blank_en into a flag.
  - Clear the BCD accumulator (4*DIGITS bits) and the overflow accumulator.
  - Load the bit counter with WIDTH (counter width $clog2(WIDTH+1)), then go to SHIFT.
- SHIFT, once per cycle:
  - Every BCD nibble ≥5 gets +3, all nibbles in parallel.
  - Then shift {BCD, bin} left by one.
  - The bit shifted out of the top nibble ORs into the overflow accumulator.
  - Decrement the counter. When it reaches 0 after the WIDTH-th shift, go to UPDATE.
- UPDATE, one cycle:
  - Register bcd_out and overflow.
  - Register seg_out:
    - if overflow, every digit shows dash;
    - else each digit shows its decimal code;
    - if the blank flag is set, every zero digit above the most significant nonzero digit shows blank. Digit 0 is never blanked, so value 0 shows "0".
  - Assert done and go to IDLE.
- in_valid outside IDLE is ignored. There is no input storage, and the value is lost unless held.
- Input is unsigned only; there is no sign handling.
- On overflow, bcd_out holds the low DIGITS decimal digits (value mod 10^DIGITS).

## Timing
- Reset values: in_ready=1, state IDLE, done=0, overflow=0, bcd_out=0.
- Reset value of seg_out: every digit shows "0" (0x3F, or 0x40 when SEG_ACTIVE_LOW).
- Acceptance happens at edge k. in_ready=0 from after edge k through the UPDATE cycle.
- WIDTH shifts occur at edges k+1..k+WIDTH.
- Outputs update and done=1 after edge k+WIDTH+1. done returns to 0 after the next edge.
- in_ready=1 in the same cycle as done. The earliest next acceptance is edge k+WIDTH+2, so the back-to-back period is WIDTH+2 cycles.
- Outputs are stable between done pulses and change only in UPDATE.
- Reset asserted mid-conversion aborts immediately: all outputs take reset values, no done is produced, and the next acceptance is the first edge after reset_n rises with in_valid=1.
- blank_en and in_data changes after acceptance have no effect on the conversion in flight.

## Test plan
- Defaults, in_data=12345, blank_en=0:
  - done exactly 17 cycles after acceptance;
  - bcd_out=0x12345;
  - seg_out digits 4..0 = ~{0x06,0x5B,0x4F,0x66,0x6D};
  - overflow=0.
- in_data=42, blank_en=1: digits 4..2 = 0x7F (blank, active low), digit1=~0x66, digit0=~0x5B. Repeat with blank_en=0: digits 4..2 = ~0x3F.
- in_data=0, blank_en=1: digit0=~0x3F, digits 4..1 blank; bcd_out=0.
- DIGITS=4, in_data=65535: overflow=1, all four digits ~0x40 (dash), bcd_out=0x5535.
- Back-to-back with in_valid held high, values 9999 then 10000: two done pulses 18 cycles apart; in_valid asserted while busy is not accepted.
- Assert reset_n=0 at shift 7 of a conversion:
  - outputs return to reset values immediately;
  - no done pulse;
  - a new conversion of 7 after release completes normally with digit0=~0x07.

Source files
------------

// File: rtl/bin2seg_seq.sv
// ---------------------------------------------------------------------------
// bin2seg_seq
//
// Sequential binary-to-decimal seven-segment driver. An unsigned WIDTH-bit
// value is accepted through a valid/ready handshake. It is converted by a
// double-dabble (shift / add-3) engine at one bit per clock. The result is
// presented as DIGITS registered seven-segment codes plus the raw BCD.
//
// Parameters
//   WIDTH          input value width, 4..32
//   DIGITS         number of decimal digits / displays, 1..10
//   SEG_ACTIVE_LOW 1 = segment lit when its bit is 0, 0 = lit when 1
//
// Ports
//   clk       sole clock, rising edge
//   reset_n   asynchronous active-low reset
//   in_valid  in_data / blank_en are presented
//   in_ready  block is idle and accepts on this edge
//   in_data   unsigned value to convert
//   blank_en  leading-zero blanking for this conversion
//   seg_out   digit i at [7i+6:7i], bit order g..a, digit 0 least significant
//   bcd_out   BCD result, digit i at [4i+3:4i]
//   overflow  last conversion did not fit in DIGITS digits
//   done      one-cycle pulse when the outputs have just updated
// ---------------------------------------------------------------------------
module bin2seg_seq #(
    parameter int WIDTH          = 16,
    parameter int DIGITS         = 5,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  blank_en,
    output logic [7*DIGITS-1:0]   seg_out,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic                  done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;
    localparam int SW = 7 * DIGITS;

    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_ZERO_OUT = SEG_ACTIVE_LOW ? 7'h40 : 7'h3F;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        UPDATE
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic [BW-1:0]   bcd_adj;
    logic            ovf_acc_q, ovf_acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            blank_q, blank_d;

    logic [SW-1:0]   seg_out_q, seg_d;
    logic [BW-1:0]   bcd_out_q;
    logic            overflow_q;
    logic            done_q;

    logic            seen;
    logic [3:0]      nib;
    logic [6:0]      code;

    // Active-high segment pattern for one decimal digit.
    function automatic logic [6:0] segCode(input logic [3:0] d);
        case (d)
            4'd0:    segCode = 7'h3F;
            4'd1:    segCode = 7'h06;
            4'd2:    segCode = 7'h5B;
            4'd3:    segCode = 7'h4F;
            4'd4:    segCode = 7'h66;
            4'd5:    segCode = 7'h6D;
            4'd6:    segCode = 7'h7D;
            4'd7:    segCode = 7'h07;
            4'd8:    segCode = 7'h7F;
            4'd9:    segCode = 7'h6F;
            default: segCode = SEG_DASH;
        endcase
    endfunction

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. The counter holds the number of shifts still to do,
    // so the last shift happens while it reads 1.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = SHIFT;
            SHIFT:   if (cnt_q == CW'(1)) state_d = UPDATE;
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        in_ready = (state_q == IDLE);
    end

    // Add-3 correction on every nibble in parallel, ahead of the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion datapath next state. Any bit leaving the top nibble means
    // the value needs more than DIGITS decimal digits.
    always_comb begin
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        ovf_acc_d = ovf_acc_q;
        cnt_d     = cnt_q;
        blank_d   = blank_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d     = in_data;
                    bcd_d     = '0;
                    ovf_acc_d = 1'b0;
                    cnt_d     = CW'(WIDTH);
                    blank_d   = blank_en;
                end
            end
            SHIFT: begin
                bcd_d     = {bcd_adj[BW-2:0], bin_q[WIDTH-1]};
                bin_d     = {bin_q[WIDTH-2:0], 1'b0};
                ovf_acc_d = ovf_acc_q | bcd_adj[BW-1];
                cnt_d     = cnt_q - CW'(1);
            end
            default: ;
        endcase
    end

    // Conversion datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_q     <= '0;
            bcd_q     <= '0;
            ovf_acc_q <= 1'b0;
            cnt_q     <= '0;
            blank_q   <= 1'b0;
        end else begin
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            ovf_acc_q <= ovf_acc_d;
            cnt_q     <= cnt_d;
            blank_q   <= blank_d;
        end
    end

    // Segment codes for the finished conversion. Scanning from the top
    // digit down, 'seen' marks that a nonzero digit has been passed, so
    // only leading zeros blank. Digit 0 always shows.
    always_comb begin
        seg_d = '0;
        seen  = 1'b0;
        nib   = '0;
        code  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib = bcd_q[4*i +: 4];
            if (ovf_acc_q) begin
                code = SEG_DASH;
            end else if (blank_q && !seen && (nib == 4'd0) && (i != 0)) begin
                code = SEG_BLANK;
            end else begin
                code = segCode(nib);
            end
            if (nib != 4'd0) begin
                seen = 1'b1;
            end
            seg_d[7*i +: 7] = SEG_ACTIVE_LOW ? ~code : code;
        end
    end

    // Output registers, loaded only in UPDATE, so they stay stable
    // between done pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_out_q  <= {DIGITS{SEG_ZERO_OUT}};
            bcd_out_q  <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= (state_q == UPDATE);
            if (state_q == UPDATE) begin
                seg_out_q  <= seg_d;
                bcd_out_q  <= bcd_q;
                overflow_q <= ovf_acc_q;
            end
        end
    end

    assign seg_out  = seg_out_q;
    assign bcd_out  = bcd_out_q;
    assign overflow = overflow_q;
    assign done     = done_q;

endmodule

// File: tb/tb_bin2seg_seq.sv
// ---------------------------------------------------------------------------
// tb_bin2seg_seq
//
// Scoreboard bench for bin2seg_seq. Instance A uses the default parameters
// (16 bits, 5 digits, active-low). Instance B uses 4 digits for the
// overflow cases. Stimulus pushes the hand-computed expected response when
// a value is accepted. Per-instance monitors pop and compare on each done.
// ---------------------------------------------------------------------------
module tb_bin2seg_seq;

    typedef struct {
        logic [34:0] seg;
        logic [19:0] bcd;
        logic        ovf;
        int          accept;
    } exp_t;

    logic        clk;
    logic        reset_n;

    logic        validA, readyA, blankA, ovfA, doneA;
    logic [15:0] dataA;
    logic [34:0] segA;
    logic [19:0] bcdA;

    logic        validB, readyB, blankB, ovfB, doneB;
    logic [15:0] dataB;
    logic [27:0] segB;
    logic [15:0] bcdB;

    exp_t qA[$];
    exp_t qB[$];
    exp_t eA, eB;

    int   cycle;
    int   total;
    int   bad;
    logic prevDoneA, prevDoneB;
    int   acc1, acc2, accTmp;

    bin2seg_seq #(.WIDTH(16), .DIGITS(5), .SEG_ACTIVE_LOW(1'b1)) dutA (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (validA),
        .in_ready (readyA),
        .in_data  (dataA),
        .blank_en (blankA),
        .seg_out  (segA),
        .bcd_out  (bcdA),
        .overflow (ovfA),
        .done     (doneA)
    );

    bin2seg_seq #(.WIDTH(16), .DIGITS(4), .SEG_ACTIVE_LOW(1'b1)) dutB (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (validB),
        .in_ready (readyB),
        .in_data  (dataB),
        .blank_en (blankB),
        .seg_out  (segB),
        .bcd_out  (bcdB),
        .overflow (ovfB),
        .done     (doneB)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle number of the most recent rising edge.
    always @(posedge clk) begin
        cycle <= cycle + 1;
    end

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input exp_t e, input logic [34:0] seg,
                               input logic [19:0] bcd, input logic ovf, input int now);
        checkVal({name, " seg_out"}, 64'(seg), 64'(e.seg));
        checkVal({name, " bcd_out"}, 64'(bcd), 64'(e.bcd));
        checkVal({name, " overflow"}, 64'(ovf), 64'(e.ovf));
        checkVal({name, " latency"}, 64'(now - e.accept), 64'd17);
    endtask

    // Present a value, wait (bounded) until it is accepted, record the
    // expectation and return just after the accepting edge. in_valid stays
    // high so consecutive calls give a back-to-back stream.
    task automatic applyStimulus(input int sel, input logic [15:0] data, input logic blank,
                                 input logic [34:0] seg, input logic [19:0] bcd,
                                 input logic ovf, output int acc);
        int   waited;
        exp_t e;
        waited = 0;
        acc    = -1;
        @(negedge clk);
        if (sel == 0) begin
            validA = 1'b1; dataA = data; blankA = blank;
        end else begin
            validB = 1'b1; dataB = data; blankB = blank;
        end
        while (!((sel == 0) ? readyA : readyB) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) begin
            total++;
            bad++;
            $display("[TB] FAIL accept timeout: got in_ready=0 expected in_ready=1");
        end else begin
            e.seg    = seg;
            e.bcd    = bcd;
            e.ovf    = ovf;
            e.accept = cycle + 1;
            acc      = e.accept;
            if (sel == 0) qA.push_back(e);
            else          qB.push_back(e);
        end
        @(posedge clk);
    endtask

    // Drop in_valid and scramble the inputs so in-flight conversions show
    // they ignore post-acceptance changes.
    task automatic releaseInput();
        @(negedge clk);
        validA = 1'b0; dataA = 16'hFFFF; blankA = ~blankA;
        validB = 1'b0; dataB = 16'hFFFF; blankB = ~blankB;
    endtask

    task automatic waitDrain();
        int waited;
        waited = 0;
        while ((qA.size() != 0 || qB.size() != 0) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) begin
            total++;
            bad++;
            $display("[TB] FAIL drain timeout: got %0d pending expected 0", qA.size() + qB.size());
            qA.delete();
            qB.delete();
        end
        @(negedge clk);
    endtask

    // Monitor for instance A.
    always @(negedge clk) begin
        if (reset_n) begin
            if (doneA) begin
                if (qA.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL A unexpected done: got done=1 expected done=0");
                end else begin
                    eA = qA.pop_front();
                    checkOutput("A", eA, segA, bcdA, ovfA, cycle);
                end
            end
            if (prevDoneA) checkVal("A done pulse width", 64'(doneA), 64'd0);
        end
        prevDoneA = doneA;
    end

    // Monitor for instance B.
    always @(negedge clk) begin
        if (reset_n) begin
            if (doneB) begin
                if (qB.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL B unexpected done: got done=1 expected done=0");
                end else begin
                    eB = qB.pop_front();
                    checkOutput("B", eB, {7'b0, segB}, {4'b0, bcdB}, ovfB, cycle);
                end
            end
            if (prevDoneB) checkVal("B done pulse width", 64'(doneB), 64'd0);
        end
        prevDoneB = doneB;
    end

    initial begin
        total = 0; bad = 0; cycle = 0;
        prevDoneA = 1'b0; prevDoneB = 1'b0;
        reset_n = 1'b0;
        validA = 1'b0; dataA = '0; blankA = 1'b0;
        validB = 1'b0; dataB = '0; blankB = 1'b0;

        // Reset state of both instances.
        repeat (2) @(posedge clk);
        #1;
        checkVal("A reset seg_out", 64'(segA), 64'({5{7'h40}}));
        checkVal("A reset bcd_out", 64'(bcdA), 64'd0);
        checkVal("A reset overflow", 64'(ovfA), 64'd0);
        checkVal("A reset done", 64'(doneA), 64'd0);
        checkVal("A reset in_ready", 64'(readyA), 64'd1);
        checkVal("B reset seg_out", 64'(segB), 64'({4{7'h40}}));
        checkVal("B reset in_ready", 64'(readyB), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // Main conversions on the 5-digit instance.
        applyStimulus(0, 16'd12345, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12}, 20'h12345, 1'b0, accTmp);
        releaseInput();
        waitDrain();
        applyStimulus(0, 16'd42, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24}, 20'h00042, 1'b0, accTmp);
        releaseInput();
        waitDrain();
        applyStimulus(0, 16'd42, 1'b0, {7'h40, 7'h40, 7'h40, 7'h19, 7'h24}, 20'h00042, 1'b0, accTmp);
        releaseInput();
        waitDrain();
        applyStimulus(0, 16'd0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, 20'h00000, 1'b0, accTmp);
        releaseInput();
        waitDrain();
        applyStimulus(0, 16'd100, 1'b1, {7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40}, 20'h00100, 1'b0, accTmp);
        releaseInput();
        waitDrain();
        applyStimulus(0, 16'd65535, 1'b0, {7'h02, 7'h12, 7'h12, 7'h30, 7'h12}, 20'h65535, 1'b0, accTmp);
        releaseInput();
        waitDrain();

        // Back-to-back with in_valid held high throughout.
        applyStimulus(0, 16'd9999, 1'b0, {7'h40, 7'h10, 7'h10, 7'h10, 7'h10}, 20'h09999, 1'b0, acc1);
        applyStimulus(0, 16'd10000, 1'b0, {7'h79, 7'h40, 7'h40, 7'h40, 7'h40}, 20'h10000, 1'b0, acc2);
        checkVal("A back-to-back period", 64'(acc2 - acc1), 64'd18);
        releaseInput();
        waitDrain();

        // Reset during the seventh shift aborts the conversion.
        applyStimulus(0, 16'd12345, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12}, 20'h12345, 1'b0, accTmp);
        releaseInput();
        repeat (6) @(posedge clk);
        #1;
        reset_n = 1'b0;
        qA.delete();
        #1;
        checkVal("A abort seg_out", 64'(segA), 64'({5{7'h40}}));
        checkVal("A abort bcd_out", 64'(bcdA), 64'd0);
        checkVal("A abort overflow", 64'(ovfA), 64'd0);
        checkVal("A abort done", 64'(doneA), 64'd0);
        checkVal("A abort in_ready", 64'(readyA), 64'd1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        applyStimulus(0, 16'd7, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40, 7'h78}, 20'h00007, 1'b0, accTmp);
        releaseInput();
        waitDrain();

        // Overflow boundary on the 4-digit instance.
        applyStimulus(1, 16'd65535, 1'b0, {7'h00, 7'h3F, 7'h3F, 7'h3F, 7'h3F}, 20'h05535, 1'b1, accTmp);
        releaseInput();
        waitDrain();
        applyStimulus(1, 16'd9999, 1'b1, {7'h00, 7'h10, 7'h10, 7'h10, 7'h10}, 20'h09999, 1'b0, accTmp);
        releaseInput();
        waitDrain();
        applyStimulus(1, 16'd10000, 1'b1, {7'h00, 7'h3F, 7'h3F, 7'h3F, 7'h3F}, 20'h00000, 1'b1, accTmp);
        releaseInput();
        waitDrain();

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
